mem_req_master: RTL and testbench
=================================

// Module: mem_req_master
// PURPOSE
//  Initiator side of the single-beat req/ready memory interface (req, rnw, addr, wdata -> ready, rdata).
//  On start, writes NUM_TXN pattern words to consecutive addresses, then reads them back and compares.
//  Reports pass/fail, error count, first failing address and a ready timeout.
//  Sits in front of the simple memory responder as a self-test / traffic master.
// PARAMETERS
//  ADDR_W   4    address width; memory depth 2**ADDR_W
//  DATA_W   32   data width
//  NUM_TXN  10   writes (and reads) per run; 1..2**ADDR_W, elaboration error otherwise
//  TIMEOUT  16   max cycles req_o may wait for ready; 0 disables timeout
// PORTS
//  clk               in   1       clock, rising edge
//  reset_n           in   1       asynchronous reset, active low
//  start_i           in   1       start pulse; sampled only in IDLE
//  seed_i            in   DATA_W  pattern seed, captured at start
//  base_addr_i       in   ADDR_W  first address, captured at start
//  req_o             out  1       request valid
//  req_rnw_o         out  1       1=read, 0=write
//  req_addr_o        out  ADDR_W  request address
//  req_wdata_o       out  DATA_W  write data (0 during reads)
//  req_ready_i       in   1       responder ready; handshake = req_o & req_ready_i
//  req_rdata_i       in   DATA_W  read data, valid in read handshake cycle
//  busy_o            out  1       run in progress
//  done_o            out  1       one-cycle pulse at end of run
//  pass_o            out  1       last run result; held until next start
//  err_cnt_o         out  ADDR_W+1  read mismatches in last run (saturates)
//  first_err_addr_o  out  ADDR_W  address of first mismatch; 0 if none
//  timeout_o         out  1       last run aborted on timeout; held until next start
// BEHAVIOUR
//  Reset (async, immediate): state IDLE; all outputs 0, incl. req_o, pass_o, counters.
//  FSM: IDLE -> WR_REQ -> WR_GAP -> (WR_REQ | RD_REQ) -> RD_GAP -> (RD_REQ | DONE) -> IDLE.
//  IDLE: start_i=1 at edge k -> capture seed/base, idx=0, clear results, busy_o=1 and req_o=1 from k+1.
//  REQ states: req_o, rnw, addr, wdata registered and stable until handshake; no change while waiting.
//  Handshake edge: req_o drops next cycle (GAP state, exactly one idle cycle between transactions).
//  GAP: idx++; if idx==NUM_TXN, WR phase -> RD_REQ with idx=0, RD phase -> DONE; else next REQ.
//  Address: req_addr_o = base + idx, mod 2**ADDR_W (wraps past max address).
//  Write data: seed + idx, mod 2**DATA_W. Read expected value computed identically.
//  Read compare in handshake cycle: mismatch -> err_cnt++ (saturating); first mismatch latches addr.
//  Timeout: wait counter resets on each new request; reaching TIMEOUT cycles without ready -> req_o drops,
//   go to DONE, timeout_o=1, pass_o=0. TIMEOUT=0: wait forever.
//  DONE (1 cycle): done_o=1, busy_o drops; pass_o = !timeout & err_cnt==0. Then IDLE.
//  done_o one cycle after final read handshake's GAP cycle; start_i while busy ignored.
//  Mid-run reset_n: run abandoned, no partial result kept; next start runs from scratch.
// STRUCTURE
//  Package mem_req_pkg: state enum (IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, DONE), RNW_READ/RNW_WRITE consts.
//  One natural sub-module: mem_req_pattern (seed, base, idx -> addr, data), shared by write and compare.
//  Timeout counter sized $clog2(TIMEOUT+1), min 1 bit.
// TESTING (bench instantiates the memory responder, defaults unless noted)
//  1 seed=0x1234_0000, base=0, start -> writes addr 0..9 data 0x1234_0000..09, reads 0..9, done, pass=1, err_cnt=0.
//  2 base=0xC -> addresses 12,13,14,15,0,1..5; pass=1; one idle cycle between every handshake.
//  3 bench flips rdata bit0 on read of addr 3 -> pass=0, err_cnt=1, first_err_addr=3.
//  4 ready forced low -> after 16 cycles req_o drops, done pulse, timeout=1, pass=0;
//    ready low 5 cycles then high -> req fields stable throughout, no timeout.
//  5 start pulsed during run -> ignored, result unchanged;
//    reset_n low mid-write -> req_o/busy_o 0 same cycle, next start passes.
//  6 NUM_TXN=16, base=0 -> all 16 addresses written and verified, pass=1.

Source files
------------

// File: rtl/mem_req_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_pkg
// Purpose  : Shared types and constants for the mem_req_master traffic master.
//            Holds the run-sequencing state encoding and the rnw encoding
//            of the single-beat req/ready memory interface.
// Revision : 1.0 - initial release
// ============================================================================
package mem_req_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_REQ = 3'd1,
    WR_GAP = 3'd2,
    RD_REQ = 3'd3,
    RD_GAP = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic RNW_READ  = 1'b1;
  localparam logic RNW_WRITE = 1'b0;

endpackage
`default_nettype wire

// File: rtl/mem_req_pattern.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_pattern
// Purpose  : Pattern generator shared by the write phase and the read-back
//            compare, so both always agree on address and data for an index.
// Ports    : i_seed  - captured pattern seed
//            i_base  - captured first address
//            i_idx   - transaction index within the current phase
//            o_addr  - base + idx, wrapping at 2**ADDR_W
//            o_data  - seed + idx, wrapping at 2**DATA_W
// Revision : 1.0 - initial release
// ============================================================================
module mem_req_pattern #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5
) (
  input  logic [DATA_W-1:0] i_seed,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [IDX_W-1:0]  i_idx,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data
);

  // Index never exceeds 2**ADDR_W, so its low ADDR_W bits are enough for the
  // wrapping address; the data path uses the full index.
  assign o_addr = i_base + i_idx[ADDR_W-1:0];
  assign o_data = i_seed + DATA_W'(i_idx);

endmodule
`default_nettype wire

// File: rtl/mem_req_master.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_master
// Purpose  : Self-test initiator for the single-beat req/ready memory
//            interface. On start it writes NUM_TXN pattern words to
//            consecutive (wrapping) addresses, reads them back, compares,
//            and reports pass/fail, error count, first failing address and
//            a ready timeout.
// Ports    : clk, reset_n          - clock / async active-low reset
//            start_i, seed_i,
//            base_addr_i           - run control, captured in IDLE
//            req_o, req_rnw_o,
//            req_addr_o,
//            req_wdata_o           - request channel to the responder
//            req_ready_i,
//            req_rdata_i           - responder handshake and read data
//            busy_o, done_o        - run status
//            pass_o, err_cnt_o,
//            first_err_addr_o,
//            timeout_o             - result of the last run
// Revision : 1.0 - initial release
// ============================================================================
module mem_req_master
  import mem_req_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32,
  parameter int NUM_TXN = 10,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_i,
  input  logic [DATA_W-1:0] seed_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  output logic              req_o,
  output logic              req_rnw_o,
  output logic [ADDR_W-1:0] req_addr_o,
  output logic [DATA_W-1:0] req_wdata_o,
  input  logic              req_ready_i,
  input  logic [DATA_W-1:0] req_rdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [ADDR_W:0]   err_cnt_o,
  output logic [ADDR_W-1:0] first_err_addr_o,
  output logic              timeout_o
);

  localparam int IDX_W = ADDR_W + 1;
  localparam int ERR_W = ADDR_W + 1;
  localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [IDX_W-1:0] c_NUM_TXN  = IDX_W'(NUM_TXN);
  localparam logic [TMO_W-1:0] c_TMO_LAST = TMO_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  generate
    if ((NUM_TXN < 1) || (NUM_TXN > (2 ** ADDR_W))) begin : g_bad_num_txn
      $error("mem_req_master: NUM_TXN must be in 1..2**ADDR_W");
    end
  endgenerate

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_seed;
  logic [ADDR_W-1:0] r_base;
  logic [IDX_W-1:0]  r_idx;
  logic [TMO_W-1:0]  r_wait_cnt;
  logic [ERR_W-1:0]  r_err_cnt;
  logic [ADDR_W-1:0] r_first_err_addr;
  logic              r_pass;
  logic              r_timeout;

  logic [ADDR_W-1:0] w_pat_addr;
  logic [DATA_W-1:0] w_pat_data;
  logic [IDX_W-1:0]  w_idx_inc;
  logic              w_req;
  logic              w_hs;
  logic              w_last;
  logic              w_tmo_hit;
  logic              w_mismatch;

  mem_req_pattern #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_pattern (
    .i_seed (r_seed),
    .i_base (r_base),
    .i_idx  (r_idx),
    .o_addr (w_pat_addr),
    .o_data (w_pat_data)
  );

  assign w_req      = (r_state == WR_REQ) || (r_state == RD_REQ);
  assign w_hs       = w_req && req_ready_i;
  assign w_idx_inc  = r_idx + IDX_W'(1);
  assign w_last     = (w_idx_inc == c_NUM_TXN);
  // The request has already been held c_TMO_LAST cycles; this is its last
  // permitted cycle without ready, so req_o is up for exactly TIMEOUT cycles.
  assign w_tmo_hit  = (TIMEOUT != 0) && w_req && !req_ready_i && (r_wait_cnt == c_TMO_LAST);
  assign w_mismatch = (req_rdata_i != w_pat_data);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start_i) w_state_nxt = WR_REQ;
      WR_REQ:  if (w_hs) w_state_nxt = WR_GAP;
               else if (w_tmo_hit) w_state_nxt = DONE;
      WR_GAP:  w_state_nxt = w_last ? RD_REQ : WR_REQ;
      RD_REQ:  if (w_hs) w_state_nxt = RD_GAP;
               else if (w_tmo_hit) w_state_nxt = DONE;
      RD_GAP:  w_state_nxt = w_last ? DONE : RD_REQ;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Run datapath: captured run parameters, index, wait counter and results
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_seed           <= '0;
      r_base           <= '0;
      r_idx            <= '0;
      r_wait_cnt       <= '0;
      r_err_cnt        <= '0;
      r_first_err_addr <= '0;
      r_pass           <= 1'b0;
      r_timeout        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_seed           <= seed_i;
            r_base           <= base_addr_i;
            r_idx            <= '0;
            r_wait_cnt       <= '0;
            r_err_cnt        <= '0;
            r_first_err_addr <= '0;
            r_pass           <= 1'b0;
            r_timeout        <= 1'b0;
          end
        end
        WR_REQ, RD_REQ: begin
          if (!w_hs) begin
            r_wait_cnt <= r_wait_cnt + TMO_W'(1);
          end
          if (w_tmo_hit) begin
            r_timeout <= 1'b1;
          end
          if ((r_state == RD_REQ) && w_hs && w_mismatch) begin
            if (r_err_cnt == '0) begin
              r_first_err_addr <= w_pat_addr;
            end
            if (r_err_cnt != '1) begin
              r_err_cnt <= r_err_cnt + ERR_W'(1);
            end
          end
        end
        WR_GAP, RD_GAP: begin
          r_wait_cnt <= '0;
          r_idx      <= w_last ? '0 : w_idx_inc;
          // Last read completed: result is visible during the DONE cycle.
          if ((r_state == RD_GAP) && w_last) begin
            r_pass <= (r_err_cnt == '0);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: decoded from registered state and registered run parameters,
  // so request fields cannot move while waiting for ready.
  // --------------------------------------------------------------------------
  assign req_o            = w_req;
  assign req_rnw_o        = (r_state == RD_REQ) ? RNW_READ : RNW_WRITE;
  assign req_addr_o       = w_req ? w_pat_addr : '0;
  assign req_wdata_o      = (r_state == WR_REQ) ? w_pat_data : '0;
  assign busy_o           = (r_state == WR_REQ) || (r_state == WR_GAP) ||
                            (r_state == RD_REQ) || (r_state == RD_GAP);
  assign done_o           = (r_state == DONE);
  assign pass_o           = r_pass;
  assign err_cnt_o        = r_err_cnt;
  assign first_err_addr_o = r_first_err_addr;
  assign timeout_o        = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mem_req_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_req_master
// Purpose  : Scoreboard bench for mem_req_master with a behavioural memory
//            responder. A second instance runs the full-depth (NUM_TXN=16)
//            configuration.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_req_master;

  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 32;
  localparam int NUM_TXN = 10;
  localparam int TIMEOUT = 16;
  localparam int DEPTH   = 2 ** ADDR_W;

  // ready modes
  localparam int M_RANDOM = 0;
  localparam int M_LOW    = 1;
  localparam int M_STALL5 = 2;
  localparam int M_HIGH   = 3;

  typedef struct packed {
    logic              rnw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } txn_t;

  typedef struct packed {
    logic              pass;
    logic [ADDR_W:0]   err;
    logic [ADDR_W-1:0] first;
    logic              tmo;
  } res_t;

  logic clk = 1'b0;
  logic reset_n;
  logic start_i;
  logic [DATA_W-1:0] seed_i;
  logic [ADDR_W-1:0] base_addr_i;
  logic req_o, req_rnw_o, req_ready_i;
  logic [ADDR_W-1:0] req_addr_o;
  logic [DATA_W-1:0] req_wdata_o, req_rdata_i;
  logic busy_o, done_o, pass_o, timeout_o;
  logic [ADDR_W:0] err_cnt_o;
  logic [ADDR_W-1:0] first_err_addr_o;

  logic start16;
  logic [DATA_W-1:0] seed16;
  logic req16, rnw16, ready16, busy16, done16, pass16, tmo16;
  logic [ADDR_W-1:0] addr16, first16;
  logic [DATA_W-1:0] wdata16, rdata16;
  logic [ADDR_W:0] err16;

  logic [DATA_W-1:0] mem   [DEPTH];
  logic [DATA_W-1:0] mem16 [DEPTH];
  logic [DEPTH-1:0]  corrupt_mask;
  int                rmode;

  txn_t exp_q[$];
  res_t res_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  mem_req_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_TXN(NUM_TXN), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i), .seed_i(seed_i),
    .base_addr_i(base_addr_i), .req_o(req_o), .req_rnw_o(req_rnw_o),
    .req_addr_o(req_addr_o), .req_wdata_o(req_wdata_o),
    .req_ready_i(req_ready_i), .req_rdata_i(req_rdata_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .err_cnt_o(err_cnt_o),
    .first_err_addr_o(first_err_addr_o), .timeout_o(timeout_o)
  );

  mem_req_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_TXN(16), .TIMEOUT(TIMEOUT)
  ) dut16 (
    .clk(clk), .reset_n(reset_n), .start_i(start16), .seed_i(seed16),
    .base_addr_i(4'd0), .req_o(req16), .req_rnw_o(rnw16),
    .req_addr_o(addr16), .req_wdata_o(wdata16),
    .req_ready_i(ready16), .req_rdata_i(rdata16),
    .busy_o(busy16), .done_o(done16), .pass_o(pass16), .err_cnt_o(err16),
    .first_err_addr_o(first16), .timeout_o(tmo16)
  );

  // Memory responders: write on handshake, combinational read data with
  // optional single-bit corruption on selected addresses.
  always @(posedge clk) begin
    if (req_o && req_ready_i && !req_rnw_o) mem[req_addr_o] <= req_wdata_o;
    if (req16 && ready16 && !rnw16) mem16[addr16] <= wdata16;
  end
  assign req_rdata_i = req_rnw_o ? (mem[req_addr_o] ^ {31'd0, corrupt_mask[req_addr_o]}) : '0;
  assign rdata16     = rnw16 ? mem16[addr16] : '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Ready driver, updated just after each rising edge.
  initial begin
    int streak = 0;
    int stall = 0;
    req_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rmode)
        M_RANDOM: begin
          req_ready_i = (streak >= 6) ? 1'b1 : ($urandom_range(0, 3) != 0);
          streak = req_ready_i ? 0 : streak + 1;
        end
        M_LOW: req_ready_i = 1'b0;
        M_STALL5: begin
          if (!req_o) begin
            stall = 0;
            req_ready_i = 1'b0;
          end else begin
            req_ready_i = (stall >= 5);
            stall++;
          end
        end
        default: req_ready_i = 1'b1;
      endcase
    end
  end

  // Monitor: pops expected handshakes and run results as the DUT presents them.
  initial begin
    logic prev_stall = 1'b0;
    txn_t prev_f = '0;
    txn_t e;
    res_t r;
    int hs_age = 0;
    int stall_run = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_stall = 1'b0;
        hs_age = 0;
        stall_run = 0;
        continue;
      end
      if (hs_age == 1) check("gap_idle_req", req_o, 1'b0);
      if (hs_age == 2) check("gap_resume", req_o | done_o, 1'b1);
      if (hs_age != 0) hs_age = (hs_age == 2) ? 0 : hs_age + 1;
      if (req_o && prev_stall)
        check("req_stable", {req_rnw_o, req_addr_o, req_wdata_o}, prev_f);
      if (req_o && !req_ready_i) stall_run++;
      else if (req_o) stall_run = 0;
      if (req_o && req_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_hs", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("hs_rnw", req_rnw_o, e.rnw);
          check("hs_addr", req_addr_o, e.addr);
          check("hs_wdata", req_wdata_o, e.data);
        end
        hs_age = 1;
      end
      prev_stall = req_o && !req_ready_i;
      prev_f = {req_rnw_o, req_addr_o, req_wdata_o};
      if (done_o) begin
        done_cnt++;
        check("done_busy_low", busy_o, 1'b0);
        check("done_all_hs_seen", exp_q.size(), 0);
        if (res_q.size() == 0) begin
          check("unexpected_done", 1'b1, 1'b0);
        end else begin
          r = res_q.pop_front();
          check("res_pass", pass_o, r.pass);
          check("res_err_cnt", err_cnt_o, r.err);
          check("res_first_err", first_err_addr_o, r.first);
          check("res_timeout", timeout_o, r.tmo);
          if (r.tmo) check("timeout_req_cycles", stall_run, TIMEOUT);
        end
      end
    end
  end

  // Reference model: the run is NUM_TXN writes of seed+i to base+i, then the
  // same reads; each read of a corrupted address is one error.
  task automatic push_exp(input logic [DATA_W-1:0] seed, input logic [ADDR_W-1:0] base,
                          input logic [DEPTH-1:0] cmask, input bit tmo);
    int n_err = 0;
    logic [ADDR_W-1:0] first = '0;
    logic [ADDR_W-1:0] a;
    if (!tmo) begin
      for (int i = 0; i < NUM_TXN; i++)
        exp_q.push_back({1'b0, ADDR_W'(int'(base) + i), seed + DATA_W'(i)});
      for (int i = 0; i < NUM_TXN; i++) begin
        a = ADDR_W'(int'(base) + i);
        exp_q.push_back({1'b1, a, {DATA_W{1'b0}}});
        if (cmask[a]) begin
          if (n_err == 0) first = a;
          n_err++;
        end
      end
    end
    res_q.push_back({(!tmo && n_err == 0), (ADDR_W+1)'(n_err), first, tmo});
  endtask

  task automatic pulse_start(input logic [DATA_W-1:0] seed, input logic [ADDR_W-1:0] base);
    @(negedge clk);
    start_i = 1'b1;
    seed_i = seed;
    base_addr_i = base;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic run(input logic [DATA_W-1:0] seed, input logic [ADDR_W-1:0] base,
                     input logic [DEPTH-1:0] cmask, input int mode, input bit extra_start);
    int d0;
    int cyc = 0;
    rmode = mode;
    corrupt_mask = cmask;
    push_exp(seed, base, cmask, mode == M_LOW);
    d0 = done_cnt;
    pulse_start(seed, base);
    while (done_cnt == d0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (extra_start && cyc == 6) begin
        start_i = 1'b1;
        seed_i = ~seed;
        base_addr_i = base + 4'd5;
      end else begin
        start_i = 1'b0;
      end
    end
    start_i = 1'b0;
    if (done_cnt == d0) begin
      check("run_done_timeout", 1'b0, 1'b1);
      exp_q.delete();
      res_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int bad;
    int hs16;
    int cyc;
    bit seen16;
    reset_n = 1'b0;
    start_i = 1'b0;
    seed_i = '0;
    base_addr_i = '0;
    start16 = 1'b0;
    seed16 = '0;
    ready16 = 1'b1;
    corrupt_mask = '0;
    rmode = M_HIGH;

    repeat (2) @(negedge clk);
    check("rst_req", req_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_pass", pass_o, 1'b0);
    check("rst_err_cnt", err_cnt_o, '0);
    check("rst_first_err", first_err_addr_o, '0);
    check("rst_timeout", timeout_o, 1'b0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run(32'h1234_0000, 4'd0, '0, M_HIGH, 1'b0);
    run($urandom, 4'hC, '0, M_RANDOM, 1'b0);
    run($urandom, 4'd0, 16'h0008, M_HIGH, 1'b0);
    run($urandom, 4'd7, '0, M_LOW, 1'b0);
    run($urandom, 4'd2, '0, M_STALL5, 1'b0);
    run($urandom, 4'd9, 16'h0400, M_RANDOM, 1'b1);

    // Reset in the middle of the write phase.
    rmode = M_HIGH;
    corrupt_mask = '0;
    push_exp(32'hDEAD_0000, 4'd0, '0, 1'b0);
    pulse_start(32'hDEAD_0000, 4'd0);
    repeat (3) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("midrst_req", req_o, 1'b0);
    check("midrst_busy", busy_o, 1'b0);
    @(negedge clk);
    exp_q.delete();
    res_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    run(32'hBEEF_0100, 4'd3, '0, M_HIGH, 1'b0);

    for (int t = 0; t < 6; t++) begin
      run($urandom, 4'($urandom_range(0, DEPTH - 1)),
          DEPTH'($urandom & $urandom & $urandom), M_RANDOM, 1'($urandom_range(0, 1)));
    end

    // Full-depth instance: every address written and read back.
    seed16 = $urandom;
    @(negedge clk);
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    hs16 = 0;
    cyc = 0;
    seen16 = 1'b0;
    while (!seen16 && cyc < 500) begin
      if (req16 && ready16) hs16++;
      if (done16) seen16 = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    check("w16_done", seen16, 1'b1);
    check("w16_pass", pass16, 1'b1);
    check("w16_err_cnt", err16, '0);
    check("w16_timeout", tmo16, 1'b0);
    check("w16_handshakes", hs16, 32);
    bad = 0;
    for (int a = 0; a < DEPTH; a++)
      if (mem16[a] !== seed16 + DATA_W'(a)) bad++;
    check("w16_mem_contents", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
